// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-FU result FIFOs, round-robin pick, registered broadcast.
// Optional macro CDB_FLUSH_EN adds flush_i, which discards every pending result.
package cdb_pkg;
    localparam int NUM_SRBITS = 6;

    typedef struct packed {
        logic                  valid;
        logic [NUM_SRBITS-1:0] tag;
        logic [31:0]           data;
    } cdb_bus_t;
endpackage

module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_FU = 4,
    parameter int QDEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_FU-1:0]            fu_valid_i,
    input  logic [NUM_FU*NUM_SRBITS-1:0] fu_tag_i,
    input  logic [NUM_FU*32-1:0]         fu_data_i,
    output logic [NUM_FU-1:0]            fu_ready_o,
`ifdef CDB_FLUSH_EN
    input  logic                         flush_i,
`endif
    output cdb_bus_t                     cdb_o
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int RW = $clog2(NUM_FU);
    localparam int IW = RW + 1;

    logic [NUM_SRBITS-1:0] tag_mem  [NUM_FU][QDEPTH];
    logic [31:0]           data_mem [NUM_FU][QDEPTH];
    logic [PW-1:0]         wr_ptr   [NUM_FU];
    logic [PW-1:0]         rd_ptr   [NUM_FU];
    logic [CW-1:0]         count    [NUM_FU];
    logic [RW-1:0]         rr_ptr;
    logic [RW-1:0]         winner;
    logic [RW-1:0]         rr_next;
    logic [IW-1:0]         idx;
    logic                  found;
    logic                  flush;
    logic [NUM_FU-1:0]     push;
    logic [NUM_FU-1:0]     pop;

`ifdef CDB_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    // Handshake: a transfer happens on a posedge where fu_valid_i[i] && fu_ready_o[i]; ready depends
    // only on the registered count, so a full queue stays not-ready even in a cycle where it pops.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            fu_ready_o[i] = (count[i] != CW'(QDEPTH));
        end
    end

    // Round-robin search starting at rr_ptr; first non-empty queue wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = IW'(rr_ptr) + IW'(k);
            if (idx >= IW'(NUM_FU)) idx = idx - IW'(NUM_FU);
            if (!found && count[idx[RW-1:0]] != '0) begin
                found  = 1'b1;
                winner = idx[RW-1:0];
            end
        end
        rr_next = (winner == RW'(NUM_FU - 1)) ? '0 : winner + RW'(1);
    end

    // Tag-0 results complete the handshake but are dropped here.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            push[i] = fu_valid_i[i] && fu_ready_o[i] && !flush &&
                      (fu_tag_i[i*NUM_SRBITS +: NUM_SRBITS] != '0);
            pop[i]  = found && (winner == RW'(i)) && !flush;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FU; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < NUM_FU; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CW'(1);
                    2'b01:   count[i] <= count[i] - CW'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (push[i]) begin
                tag_mem[i][wr_ptr[i]]  <= fu_tag_i[i*NUM_SRBITS +: NUM_SRBITS];
                data_mem[i][wr_ptr[i]] <= fu_data_i[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (found && !flush) begin
            rr_ptr <= rr_next;
        end
    end

    // Idle cycles clear tag so downstream tag match never sees a stale hit; data is left alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_o <= '0;
        end else if (found && !flush) begin
            cdb_o.valid <= 1'b1;
            cdb_o.tag   <= tag_mem[winner][rd_ptr[winner]];
            cdb_o.data  <= data_mem[winner][rd_ptr[winner]];
        end else begin
            cdb_o.valid <= 1'b0;
            cdb_o.tag   <= '0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: hand-ordered expected broadcasts in exp_q plus per-cycle checks.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int NF  = 4;
    localparam int SRB = NUM_SRBITS;
    localparam int W   = SRB + 32;

    logic                clk;
    logic                rst_n;
    logic [NF-1:0]       fu_valid;
    logic [NF*SRB-1:0]   fu_tag;
    logic [NF*32-1:0]    fu_data;
    logic [NF-1:0]       fu_ready;
    cdb_bus_t            cdb;
`ifdef CDB_FLUSH_EN
    logic                flush;
`endif

    logic [W-1:0] exp_q[$];
    int           n_vec = 0;
    int           n_err = 0;

    cdb_arbiter #(.NUM_FU(NF), .QDEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fu_valid_i (fu_valid),
        .fu_tag_i   (fu_tag),
        .fu_data_i  (fu_data),
        .fu_ready_o (fu_ready),
`ifdef CDB_FLUSH_EN
        .flush_i    (flush),
`endif
        .cdb_o      (cdb)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fu_valid = '0;
        fu_tag   = '0;
        fu_data  = '0;
    endtask

    task automatic drive(input int i, input logic [SRB-1:0] t, input logic [31:0] d);
        fu_valid[i]           = 1'b1;
        fu_tag[i*SRB +: SRB]  = t;
        fu_data[i*32 +: 32]   = d;
    endtask

    task automatic expect_bcast(input string nm, input logic [SRB-1:0] t, input logic [31:0] d);
        check({nm, "_valid"}, 64'(cdb.valid), 64'd1);
        check({nm, "_tag"},   64'(cdb.tag),   64'(t));
        check({nm, "_data"},  64'(cdb.data),  64'(d));
    endtask

    task automatic expect_idle(input string nm);
        check({nm, "_valid"}, 64'(cdb.valid), 64'd0);
        check({nm, "_tag"},   64'(cdb.tag),   64'd0);
    endtask

    // Scoreboard: every broadcast must match the front of exp_q
    always @(negedge clk) begin
        if (rst_n && cdb.valid) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", 64'({cdb.tag, cdb.data}), 64'd0);
            end else begin
                check("sb_order", 64'({cdb.tag, cdb.data}), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin : stim
        logic [5:0]    r0_exp;
        logic [5:0]    r1_exp;
        logic [NF-1:0] rdy;
        int            n0;
        int            n1;
        r0_exp = 6'b010111;
        r1_exp = 6'b101011;

        // Reset with all FUs presenting results
        rst_n = 1'b0;
`ifdef CDB_FLUSH_EN
        flush = 1'b0;
`endif
        idle_inputs();
        for (int i = 0; i < NF; i++) drive(i, SRB'(i + 1), 32'h1000 + 32'(i));
        repeat (3) step();
        check("rst_valid", 64'(cdb.valid), 64'd0);
        check("rst_tag",   64'(cdb.tag),   64'd0);
        check("rst_data",  64'(cdb.data),  64'd0);
        check("rst_ready", 64'(fu_ready),  64'hF);
        idle_inputs();
        rst_n = 1'b1;
        step();
        expect_idle("post_rst0");
        check("post_rst_ready", 64'(fu_ready), 64'hF);
        step();
        expect_idle("post_rst1");

        // Single result from FU2
        drive(2, 6'd5, 32'hDEAD_BEEF);
        exp_q.push_back({6'd5, 32'hDEAD_BEEF});
        step();
        check("single_nobypass", 64'(cdb.valid), 64'd0);
        check("single_ready", 64'(fu_ready), 64'hF);
        idle_inputs();
        step();
        expect_bcast("single", 6'd5, 32'hDEAD_BEEF);
        step();
        expect_idle("single_after");
        check("single_data_hold", 64'(cdb.data), 64'hDEAD_BEEF);

        // Bring rr_ptr back to 0 via a lone FU3 win
        drive(3, 6'h03, 32'h3333_0003);
        exp_q.push_back({6'h03, 32'h3333_0003});
        step();
        idle_inputs();
        step();
        expect_bcast("rr_align", 6'h03, 32'h3333_0003);
        step();

        // Round-robin: all four push at once
        for (int i = 0; i < NF; i++) begin
            drive(i, SRB'(6'h10 + i), 32'hA0 + 32'(i));
            exp_q.push_back({SRB'(6'h10 + i), 32'hA0 + 32'(i)});
        end
        step();
        idle_inputs();
        for (int i = 0; i < NF; i++) begin
            step();
            expect_bcast($sformatf("rr4_fu%0d", i), SRB'(6'h10 + i), 32'hA0 + 32'(i));
        end
        step();
        expect_idle("rr4_done");

        // FU3 and FU1 push with rr_ptr=0: FU1 first
        drive(3, 6'h23, 32'hB3);
        drive(1, 6'h21, 32'hB1);
        exp_q.push_back({6'h21, 32'hB1});
        exp_q.push_back({6'h23, 32'hB3});
        step();
        idle_inputs();
        step();
        expect_bcast("rr2_first", 6'h21, 32'hB1);
        step();
        expect_bcast("rr2_second", 6'h23, 32'hB3);
        step();
        expect_idle("rr2_done");

        // Backpressure: FU0 and FU1 offer every cycle for 6 cycles
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({SRB'(6'h30 + k), 32'h4000_0030 + 32'(k)});
            exp_q.push_back({SRB'(6'h38 + k), 32'h4000_0038 + 32'(k)});
        end
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("bp_ready0_%0d", k), 64'(fu_ready[0]), 64'(r0_exp[k]));
            check($sformatf("bp_ready1_%0d", k), 64'(fu_ready[1]), 64'(r1_exp[k]));
            drive(0, SRB'(6'h30 + n0), 32'h4000_0030 + 32'(n0));
            drive(1, SRB'(6'h38 + n1), 32'h4000_0038 + 32'(n1));
            rdy = fu_ready;
            step();
            if (rdy[0]) n0++;
            if (rdy[1]) n1++;
        end
        idle_inputs();
        repeat (4) step();
        expect_idle("bp_drained");
        check("bp_sb_empty", 64'(exp_q.size()), 64'd0);

        // Tag 0 is accepted but never queued
        for (int k = 0; k < 3; k++) begin
            drive(3, 6'd0, 32'd7);
            step();
            check($sformatf("tag0_ready_%0d", k), 64'(fu_ready[3]), 64'd1);
            expect_idle($sformatf("tag0_%0d", k));
        end
        idle_inputs();
        step();
        expect_idle("tag0_after");

        // Three results queued (rr_ptr=2): flush, or drain FU2, FU0, FU1
        drive(0, 6'h2A, 32'hC0);
        drive(1, 6'h2B, 32'hC1);
        drive(2, 6'h2C, 32'hC2);
`ifdef CDB_FLUSH_EN
        step();
        idle_inputs();
        flush = 1'b1;
        step();
        flush = 1'b0;
        expect_idle("flush_now");
        check("flush_ready", 64'(fu_ready), 64'hF);
        for (int k = 0; k < 3; k++) begin
            step();
            expect_idle($sformatf("flush_after_%0d", k));
        end
`else
        exp_q.push_back({6'h2C, 32'hC2});
        exp_q.push_back({6'h2A, 32'hC0});
        exp_q.push_back({6'h2B, 32'hC1});
        step();
        idle_inputs();
        step();
        expect_bcast("drain0", 6'h2C, 32'hC2);
        step();
        expect_bcast("drain1", 6'h2A, 32'hC0);
        step();
        expect_bcast("drain2", 6'h2B, 32'hC1);
        step();
        expect_idle("drain_done");
`endif

        // Reset mid-operation drops the remaining queued results
        drive(0, 6'h15, 32'hD0);
        drive(1, 6'h16, 32'hD1);
        drive(2, 6'h17, 32'hD2);
        exp_q.push_back({6'h17, 32'hD2});
        step();
        idle_inputs();
        step();
        expect_bcast("midrst_first", 6'h17, 32'hD2);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(cdb.valid), 64'd0);
        check("midrst_tag",   64'(cdb.tag),   64'd0);
        check("midrst_data",  64'(cdb.data),  64'd0);
        check("midrst_ready", 64'(fu_ready),  64'hF);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            expect_idle($sformatf("midrst_after_%0d", k));
        end

        check("final_sb_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
